aes_round_key_sequencer: RTL and testbench

//  Sits directly downstream of KeyExpansion. Captures its full expanded schedule w (all NR+1 round keys).

---
 rtl/aes_round_key_sequencer.sv | 105 ++++++++++
 tb/tb_aes_round_key_sequencer.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_key_sequencer.sv
// Captures a full AES key schedule and streams one 128-bit round key per valid/ready handshake,
// forward (encrypt) or reverse (decrypt). Optional macro AES_RK_ZEROIZE_EN wipes the schedule after use.
module aes_round_key_sequencer #(
   parameter int NK = 4,
   parameter int NR = 10
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      load,
   input  logic                      decrypt,
   input  logic [0:128*(NR+1)-1]     w_in,
   output logic                      rk_valid,
   input  logic                      rk_ready,
   output logic [0:127]              rk,
   output logic [$clog2(NR+1)-1:0]   rk_round,
   output logic                      rk_last,
   output logic                      busy,
   output logic                      done
);

   localparam int SW = 128 * (NR + 1);
   localparam int RW = $clog2(NR + 1);
   localparam logic [RW-1:0] LAST = RW'(NR);

   if (NK != 4 && NK != 6 && NK != 8) begin : g_nk_check
      $error("aes_round_key_sequencer: NK must be 4, 6 or 8");
   end

   typedef enum logic {
      S_IDLE,
      S_ISSUE
   } state_t;

   state_t          state_q, state_d;
   logic [0:SW-1]   sched_q, sched_d;
   logic            dir_q, dir_d;
   logic [RW-1:0]   idx_q, idx_d;
   logic [RW-1:0]   step_q, step_d;
   logic            done_q, done_d;
   logic [0:127]    key_sel;
   logic            hs;

   assign rk_valid = (state_q == S_ISSUE);
   assign busy     = rk_valid;
   assign rk_round = step_q;
   assign rk_last  = rk_valid && (step_q == LAST);
   assign done     = done_q;
   assign hs       = rk_valid && rk_ready;

   // idx is bounded to 0..NR by step, so the slice never leaves the schedule.
   assign key_sel  = sched_q[128*int'(idx_q) +: 128];

`ifdef AES_RK_ZEROIZE_EN
   assign rk = rk_valid ? key_sel : '0;
`else
   assign rk = key_sel;
`endif

   always_comb begin
      state_d = state_q;
      sched_d = sched_q;
      dir_d   = dir_q;
      idx_d   = idx_q;
      step_d  = step_q;
      done_d  = 1'b0;
      // load has priority: a handshake in the same cycle as a restart is discarded.
      if (load) begin
         sched_d = w_in;
         dir_d   = decrypt;
         idx_d   = decrypt ? LAST : '0;
         step_d  = '0;
         state_d = S_ISSUE;
      end else if (hs) begin
         if (step_q == LAST) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
`ifdef AES_RK_ZEROIZE_EN
            sched_d = '0;
`endif
         end else begin
            step_d = step_q + 1'b1;
            idx_d  = dir_q ? (idx_q - 1'b1) : (idx_q + 1'b1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         sched_q <= '0;
         dir_q   <= 1'b0;
         idx_q   <= '0;
         step_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sched_q <= sched_d;
         dir_q   <= dir_d;
         idx_q   <= idx_d;
         step_q  <= step_d;
         done_q  <= done_d;
      end
   end

endmodule

// File: tb/tb_aes_round_key_sequencer.sv
// Bench for aes_round_key_sequencer: FIPS-197 schedules built in-bench, a sequence/position model and random traffic.
module tb_aes_round_key_sequencer;

   localparam int SW_A = 128 * 11;
   localparam int SW_B = 128 * 15;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic            ld_a = 1'b0, dec_a = 1'b0, rdy_a = 1'b0;
   logic [0:SW_A-1] w_a = '0;
   logic            vld_a, last_a, busy_a, done_a;
   logic [0:127]    rk_a;
   logic [3:0]      rnd_a;

   logic            ld_b = 1'b0, dec_b = 1'b0, rdy_b = 1'b0;
   logic [0:SW_B-1] w_b = '0;
   logic            vld_b, last_b, busy_b, done_b;
   logic [0:127]    rk_b;
   logic [3:0]      rnd_b;

   always #5 clk = ~clk;

   aes_round_key_sequencer #(.NK(4), .NR(10)) u_a (
      .clk(clk), .rst_n(rst_n), .load(ld_a), .decrypt(dec_a), .w_in(w_a),
      .rk_valid(vld_a), .rk_ready(rdy_a), .rk(rk_a), .rk_round(rnd_a),
      .rk_last(last_a), .busy(busy_a), .done(done_a)
   );

   aes_round_key_sequencer #(.NK(8), .NR(14)) u_b (
      .clk(clk), .rst_n(rst_n), .load(ld_b), .decrypt(dec_b), .w_in(w_b),
      .rk_valid(vld_b), .rk_ready(rdy_b), .rk(rk_b), .rk_round(rnd_b),
      .rk_last(last_b), .busy(busy_b), .done(done_b)
   );

   int tests = 0;
   int fails = 0;
   bit cmp_en = 1'b0;

   logic [7:0]   sbox [256];
   logic [31:0]  ew [60];
   logic [127:0] f128 [11];
   logic [127:0] f256 [15];
   logic [127:0] tab [2][15];

   // Model: the captured key list, its order and the current issue position.
   bit           m_act  [2];
   int           m_pos  [2];
   bit           m_rev  [2];
   bit           m_done [2];
   logic [127:0] m_key  [2][15];
   logic [127:0] m_hold [2];

   task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: actual=%0h required=%0h", nm, got, exp);
      end
   endtask

   function automatic int nr_of(input int u);
      return (u != 0) ? 14 : 10;
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, aa, bb;
      p = 8'h00; aa = a; bb = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ aa;
         aa = xtime(aa);
         bb = bb >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
      return (v << n) | (v >> (8 - n));
   endfunction

   task automatic init_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         if (x != 0)
            for (int y = 1; y < 256; y++)
               if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sbox[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] subw(input logic [31:0] t);
      return {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
   endfunction

   task automatic expand(input logic [255:0] key, input int nk, input int nr);
      logic [31:0] t;
      logic [7:0]  rcon;
      rcon = 8'h01;
      for (int i = 0; i < nk; i++) ew[i] = key[255-32*i -: 32];
      for (int i = nk; i < 4*(nr+1); i++) begin
         t = ew[i-1];
         if (i % nk == 0) begin
            t = subw({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
            rcon = xtime(rcon);
         end else if (nk > 6 && i % nk == 4) begin
            t = subw(t);
         end
         ew[i] = ew[i-nk] ^ t;
      end
   endtask

   task automatic mreset();
      for (int u = 0; u < 2; u++) begin
         m_act[u] = 1'b0; m_pos[u] = 0; m_rev[u] = 1'b0; m_done[u] = 1'b0;
         m_hold[u] = '0;
         for (int r = 0; r < 15; r++) m_key[u][r] = '0;
      end
   endtask

   function automatic logic [127:0] mcur(input int u);
      return m_key[u][m_rev[u] ? (nr_of(u) - m_pos[u]) : m_pos[u]];
   endfunction

   task automatic mstep(input int u, input logic ld, input logic dec, input logic rdy);
      m_done[u] = 1'b0;
      if (ld) begin
         for (int r = 0; r <= nr_of(u); r++) m_key[u][r] = tab[u][r];
         m_rev[u] = dec; m_act[u] = 1'b1; m_pos[u] = 0;
      end else if (m_act[u] && rdy) begin
         m_hold[u] = mcur(u);
         if (m_pos[u] == nr_of(u)) begin
            m_act[u] = 1'b0; m_done[u] = 1'b1;
         end else begin
            m_pos[u]++;
         end
      end
   endtask

   initial begin
      mreset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) mreset();
         else begin
            mstep(0, ld_a, dec_a, rdy_a);
            mstep(1, ld_b, dec_b, rdy_b);
         end
      end
   end

   task automatic cmp_inst(input int u, input logic v, input logic b, input logic d,
                           input logic [3:0] rnd, input logic l, input logic [127:0] k);
      string p;
      logic [127:0] ek;
      p = (u != 0) ? "B" : "A";
`ifdef AES_RK_ZEROIZE_EN
      ek = m_act[u] ? mcur(u) : '0;
`else
      ek = m_act[u] ? mcur(u) : m_hold[u];
`endif
      chk({p, ".rk_valid"}, 128'(v), 128'(m_act[u]));
      chk({p, ".busy"},     128'(b), 128'(m_act[u]));
      chk({p, ".done"},     128'(d), 128'(m_done[u]));
      chk({p, ".rk_last"},  128'(l), 128'(m_act[u] && m_pos[u] == nr_of(u)));
      chk({p, ".rk"},       k, ek);
      if (m_act[u]) chk({p, ".rk_round"}, 128'(rnd), 128'(m_pos[u]));
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (cmp_en && rst_n) begin
            cmp_inst(0, vld_a, busy_a, done_a, rnd_a, last_a, rk_a);
            cmp_inst(1, vld_b, busy_b, done_b, rnd_b, last_b, rk_b);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic build_w();
      for (int r = 0; r <= 10; r++) w_a[128*r +: 128] = tab[0][r];
      for (int r = 0; r <= 14; r++) w_b[128*r +: 128] = tab[1][r];
   endtask

   task automatic rand_tab(input int u);
      for (int r = 0; r < 15; r++) tab[u][r] = {$urandom(), $urandom(), $urandom(), $urandom()};
   endtask

   task automatic load_a(input logic d);
      build_w(); dec_a = d; ld_a = 1'b1; tick(); ld_a = 1'b0;
   endtask

   task automatic load_b(input logic d);
      build_w(); dec_b = d; ld_b = 1'b1; tick(); ld_b = 1'b0;
   endtask

   task automatic run_to_a(input int target, input string nm);
      int c;
      c = 0;
      while (!(vld_a && int'(rnd_a) == target) && c < 60) begin tick(); c++; end
      chk({nm, " reached"}, 128'(vld_a && int'(rnd_a) == target), 128'd1);
   endtask

   task automatic wait_done_a(input string nm);
      int c;
      c = 0;
      while (!done_a && c < 80) begin tick(); c++; end
      chk({nm, " done"}, 128'(done_a), 128'd1);
   endtask

   initial begin : main
      int n, c;
      bit ld;
      init_sbox();
      expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, 10);
      for (int r = 0; r < 11; r++) f128[r] = {ew[4*r], ew[4*r+1], ew[4*r+2], ew[4*r+3]};
      expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 14);
      for (int r = 0; r < 15; r++) f256[r] = {ew[4*r], ew[4*r+1], ew[4*r+2], ew[4*r+3]};
      chk("pin f128 r0",  f128[0],  128'h000102030405060708090a0b0c0d0e0f);
      chk("pin f128 r1",  f128[1],  128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
      chk("pin f128 r10", f128[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
      chk("pin f256 r14", f256[14], 128'h24fc79ccbf0979e9371ac23c6d68de36);
      for (int r = 0; r < 15; r++) begin tab[0][r] = '0; tab[1][r] = '0; end

      repeat (2) tick();
      chk("reset rk_valid", 128'(vld_a), 128'd0);
      chk("reset busy",     128'(busy_a), 128'd0);
      chk("reset done",     128'(done_a), 128'd0);
      chk("reset rk_round", 128'(rnd_a), 128'd0);
      chk("reset rk",       rk_a, 128'd0);
      chk("reset B valid",  128'(vld_b), 128'd0);
      #2 rst_n = 1'b1;
      cmp_en = 1'b1;
      tick();

      // Forward FIPS-197 AES-128 stream with ready tied high
      for (int r = 0; r < 11; r++) tab[0][r] = f128[r];
      rdy_a = 1'b1;
      load_a(1'b0);
      chk("t1 step0 rk", rk_a, 128'h000102030405060708090a0b0c0d0e0f);
      chk("t1 step0 round", 128'(rnd_a), 128'd0);
      n = 0; c = 0;
      while (!done_a && c < 40) begin
         if (vld_a) n++;
         if (vld_a && rnd_a == 4'd10) begin
            chk("t1 step10 rk", rk_a, 128'h13111d7fe3944a17f307a78b4d2b30c5);
            chk("t1 step10 last", 128'(last_a), 128'd1);
         end
         tick(); c++;
      end
      chk("t1 valid cycles", 128'(n), 128'd11);
      chk("t1 done latency", 128'(c), 128'd11);
      chk("t1 done", 128'(done_a), 128'd1);

      // Reverse order, loaded in the done cycle
      load_a(1'b1);
      chk("t2 first rk", rk_a, 128'h13111d7fe3944a17f307a78b4d2b30c5);
      chk("t2 first round", 128'(rnd_a), 128'd0);
      run_to_a(10, "t2 step10");
      chk("t2 last rk", rk_a, 128'h000102030405060708090a0b0c0d0e0f);
      chk("t2 last flag", 128'(last_a), 128'd1);
      wait_done_a("t2");

      // Back-pressure at step 4
      load_a(1'b0);
      run_to_a(4, "t3 step4");
      rdy_a = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t3 stall round", 128'(rnd_a), 128'd4);
         chk("t3 stall valid", 128'(vld_a), 128'd1);
         chk("t3 stall rk", rk_a, f128[4]);
      end
      rdy_a = 1'b1;
      tick();
      chk("t3 resume round", 128'(rnd_a), 128'd5);
      wait_done_a("t3");

      // Abort at step 6 with a new reverse-order schedule
      load_a(1'b0);
      run_to_a(6, "t4 step6");
      rand_tab(0);
      load_a(1'b1);
      chk("t4 restart round", 128'(rnd_a), 128'd0);
      chk("t4 restart rk", rk_a, tab[0][10]);
      chk("t4 no done", 128'(done_a), 128'd0);
      n = 0; c = 0;
      while (!done_a && c < 40) begin if (vld_a) n++; tick(); c++; end
      chk("t4 new seq length", 128'(n), 128'd11);

      // Asynchronous reset mid-stream
      rand_tab(0);
      load_a(1'b0);
      run_to_a(3, "t5 step3");
      #2 rst_n = 1'b0;
      #1;
      chk("t5 rst rk_valid", 128'(vld_a), 128'd0);
      chk("t5 rst busy",     128'(busy_a), 128'd0);
      chk("t5 rst done",     128'(done_a), 128'd0);
      chk("t5 rst rk_round", 128'(rnd_a), 128'd0);
      chk("t5 rst rk",       rk_a, 128'd0);
      tick(); tick();
      #2 rst_n = 1'b1;
      tick();
      chk("t5 idle valid", 128'(vld_a), 128'd0);
      chk("t5 idle busy",  128'(busy_a), 128'd0);

      // AES-256 schedule on the NR=14 instance
      for (int r = 0; r < 15; r++) tab[1][r] = f256[r];
      rdy_b = 1'b1;
      load_b(1'b0);
      n = 0; c = 0;
      while (!done_b && c < 40) begin
         if (vld_b) n++;
         if (vld_b && rnd_b == 4'd14) begin
            chk("t6 step14 rk", rk_b, 128'h24fc79ccbf0979e9371ac23c6d68de36);
            chk("t6 step14 last", 128'(last_b), 128'd1);
         end
         tick(); c++;
      end
      chk("t6 valid cycles", 128'(n), 128'd15);
      chk("t6 done", 128'(done_b), 128'd1);
`ifdef AES_RK_ZEROIZE_EN
      chk("t6 rk zeroized", rk_b, 128'd0);
      chk("t6 sched zeroized", 128'(|u_b.sched_q), 128'd0);
`else
      chk("t6 rk held", rk_b, 128'h24fc79ccbf0979e9371ac23c6d68de36);
`endif

      // Random traffic on both instances
      for (int i = 0; i < 1500; i++) begin
         ld = vld_a ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 2) == 0);
         if (ld) begin rand_tab(0); build_w(); dec_a = 1'($urandom_range(0, 1)); end
         ld_a = ld;
         rdy_a = ($urandom_range(0, 3) != 0);
         ld = vld_b ? ($urandom_range(0, 49) == 0) : ($urandom_range(0, 3) == 0);
         if (ld) begin rand_tab(1); build_w(); dec_b = 1'($urandom_range(0, 1)); end
         ld_b = ld;
         rdy_b = ($urandom_range(0, 2) != 0);
         tick();
      end
      ld_a = 1'b0; ld_b = 1'b0; rdy_a = 1'b1; rdy_b = 1'b1;
      c = 0;
      while ((vld_a || vld_b) && c < 40) begin tick(); c++; end
      tick();
      chk("drain A idle", 128'(vld_a), 128'd0);
      chk("drain B idle", 128'(vld_b), 128'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
